apb_mgr_arbiter: RTL and testbench
==================================

# apb_mgr_arbiter

Round-robin arbiter that shares the single peripheral APB subordinate path (the input of the address-decode/demux stage) between `NumMgr` APB managers, e.g. the core and a future DMA or debug manager. It re-launches each granted transfer as a clean SETUP/ACCESS sequence and holds the grant until the response returns. A per-transfer watchdog terminates stalled accesses with an error, so a hung peripheral cannot lock out the other managers.

## Interface
Parameters:
- `NumMgr`, default 2: number of managers, ≥ 2.
- `AddrWidth`, default 32: APB address width.
- `DataWidth`, default 32: APB data width.
- `TimeoutCycles`, default 255: maximum ACCESS cycles before forced error; 0 disables the watchdog.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-high.
- `mgr_psel_i`  in  NumMgr  per-manager PSEL.
- `mgr_penable_i`  in  NumMgr  per-manager PENABLE.
- `mgr_pwrite_i`  in  NumMgr  per-manager PWRITE.
- `mgr_paddr_i`  in  NumMgr*AddrWidth  packed addresses; manager i at `[i*AddrWidth +: AddrWidth]`.
- `mgr_pwdata_i`  in  NumMgr*DataWidth  packed write data.
- `mgr_prdata_o`  out  NumMgr*DataWidth  packed read data.
- `mgr_pready_o`  out  NumMgr  per-manager PREADY.
- `mgr_pslverr_o`  out  NumMgr  per-manager PSLVERR.
- `sub_psel_o`, `sub_penable_o`, `sub_pwrite_o`  out  1  subordinate APB controls.
- `sub_paddr_o`  out  AddrWidth  subordinate address.
- `sub_pwdata_o`  out  DataWidth  subordinate write data.
- `sub_prdata_i`  in  DataWidth; `sub_pready_i`, `sub_pslverr_i`  in  1  subordinate response.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `timeout_o`  out  1  one-cycle pulse on watchdog termination.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: request vector is `mgr_psel_i`. If nonzero, pick the first requester scanning from `(last_grant+1) mod NumMgr` upward with wrap-around. Register grant index, `last_grant`, paddr, pwrite, and pwdata of the winner. Go to SETUP.
- SETUP: `sub_psel_o=1`, `sub_penable_o=0`, address, write and data driven from the captured registers. Always go to ACCESS next cycle.
- ACCESS: `sub_psel_o=1`, `sub_penable_o=1`. When `sub_pready_i=1`:
  - granted manager gets `mgr_pready_o=1`, `mgr_prdata_o=sub_prdata_i` and `mgr_pslverr_o=sub_pslverr_i`, combinationally in the same cycle;
  - go to IDLE.
- Watchdog: a counter of `$clog2(TimeoutCycles+1)` bits clears on SETUP entry and increments every ACCESS cycle with `sub_pready_i=0`. On the ACCESS cycle where count equals `TimeoutCycles` and `sub_pready_i=0`:
  - granted manager gets `mgr_pready_o=1`, `mgr_pslverr_o=1` and `mgr_prdata_o=0`;
  - `timeout_o=1`; go to IDLE.
- Non-granted managers: `mgr_pready_o=0`, `mgr_pslverr_o=0`, `mgr_prdata_o=0` at all times. A waiting APB manager simply sees wait states.
- Granted manager deasserts `mgr_psel_i` mid-transfer (protocol violation): the subordinate transfer still completes, and the response is driven but ignored by that manager.
- All managers request simultaneously: exactly one grant, following round-robin order. No manager waits more than `NumMgr-1` transfers.

## Timing
- Reset (asynchronous, active-high `rst_ni`):
  - state IDLE, counter 0, `last_grant=NumMgr-1` so manager 0 wins first;
  - captured address and data 0;
  - all `sub_*` outputs, `mgr_*` outputs, `busy_o` and `timeout_o` are 0.
- Reset mid-transfer: return to IDLE immediately. The interrupted manager receives no pready.
- Latency for a request first visible in IDLE at cycle 0:
  - SETUP at cycle 1, ACCESS at cycle 2;
  - zero-wait subordinate gives `mgr_pready_o` at cycle 2;
  - IDLE at cycle 3, where the next arbitration happens.
- Minimum 3 cycles per transfer. Each subordinate wait state adds 1 cycle.
- The `sub_*` control and address outputs are registered or decoded from the state only; no input reaches them combinationally. Response outputs are combinational from `sub_*_i` in ACCESS only.
- Timeout: with a never-ready subordinate, `mgr_pready_o` and `timeout_o` assert on ACCESS cycle `TimeoutCycles+1`, i.e. cycle `TimeoutCycles+2` after arbitration.

## Test plan
- Single read: manager 0 reads 0x0000_1004, subordinate returns 0xDEAD_BEEF with zero wait. Required: sub SETUP at cycle 1, ACCESS at cycle 2, `mgr_prdata_o[0]=0xDEAD_BEEF` with pready at cycle 2, `busy_o` low at cycle 3.
- Simultaneous writes: managers 0 and 1 write 0x11 and 0x22 in the same cycle after reset. Required: subordinate sees 0x11 first, then 0x22. Manager 1 sees pready=0 until its own completion at cycle 5.
- Fairness: both managers request continuously for 6 transfers. Required: grants alternate 0,1,0,1,0,1.
- Wait states: subordinate holds pready low for 4 ACCESS cycles and then returns pslverr=1. Required: `mgr_pready_o` and `mgr_pslverr_o` asserted together at cycle 6, with `sub_paddr_o` stable throughout.
- Timeout: `TimeoutCycles=8` with a never-ready subordinate. Required: `timeout_o` pulse, manager pready=1, pslverr=1, prdata=0 at cycle 10. The other manager's pending request is granted at cycle 11.
- Reset mid-ACCESS: assert `rst_ni` during the 2nd wait cycle. Required: all outputs 0 in the same cycle, and after release the first grant goes to manager 0.

Source files
------------

// File: rtl/apb_mgr_arbiter_if.sv
// Bus bundle between the APB managers, the arbiter and the shared subordinate path.
// The arbiter takes the slave view; the managers and subordinate model take the master view.
interface apb_mgr_arbiter_if #(
    parameter int NumMgr    = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
  logic [NumMgr-1:0]           mgr_psel_i;
  logic [NumMgr-1:0]           mgr_penable_i;
  logic [NumMgr-1:0]           mgr_pwrite_i;
  logic [NumMgr*AddrWidth-1:0] mgr_paddr_i;
  logic [NumMgr*DataWidth-1:0] mgr_pwdata_i;
  logic [NumMgr*DataWidth-1:0] mgr_prdata_o;
  logic [NumMgr-1:0]           mgr_pready_o;
  logic [NumMgr-1:0]           mgr_pslverr_o;

  logic                        sub_psel_o;
  logic                        sub_penable_o;
  logic                        sub_pwrite_o;
  logic [AddrWidth-1:0]        sub_paddr_o;
  logic [DataWidth-1:0]        sub_pwdata_o;
  logic [DataWidth-1:0]        sub_prdata_i;
  logic                        sub_pready_i;
  logic                        sub_pslverr_i;

  modport slave (
    input  mgr_psel_i, mgr_penable_i, mgr_pwrite_i, mgr_paddr_i, mgr_pwdata_i,
    output mgr_prdata_o, mgr_pready_o, mgr_pslverr_o,
    output sub_psel_o, sub_penable_o, sub_pwrite_o, sub_paddr_o, sub_pwdata_o,
    input  sub_prdata_i, sub_pready_i, sub_pslverr_i
  );

  modport master (
    output mgr_psel_i, mgr_penable_i, mgr_pwrite_i, mgr_paddr_i, mgr_pwdata_i,
    input  mgr_prdata_o, mgr_pready_o, mgr_pslverr_o,
    input  sub_psel_o, sub_penable_o, sub_pwrite_o, sub_paddr_o, sub_pwdata_o,
    output sub_prdata_i, sub_pready_i, sub_pslverr_i
  );
endinterface

// File: rtl/apb_mgr_arbiter.sv
// Round-robin arbiter sharing one APB subordinate path between NumMgr managers,
// re-launching each granted transfer as SETUP/ACCESS with a per-transfer watchdog.
module apb_mgr_arbiter #(
    parameter int NumMgr        = 2,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    apb_mgr_arbiter_if.slave    bus,
    output logic                busy_o,
    output logic                timeout_o
);
  localparam int IdxW = $clog2(NumMgr);
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state_reg;
  logic [IdxW-1:0]      grant_reg;
  logic [IdxW-1:0]      last_grant_reg;
  logic [AddrWidth-1:0] addr_reg;
  logic [DataWidth-1:0] wdata_reg;
  logic                 write_reg;
  logic                 psel_reg;
  logic                 penable_reg;
  logic                 busy_reg;
  logic [CntW-1:0]      cnt_reg;

  logic [IdxW-1:0]      winner_next;
  logic                 req_any;
  logic [IdxW-1:0]      cand;
  logic [AddrWidth-1:0] addr_next;
  logic [DataWidth-1:0] wdata_next;
  logic                 write_next;
  logic                 timeout_hit;
  logic                 resp_fire;
  logic                 unused_penable;

  // Managers' own PENABLE carries no information the re-launched transfer needs.
  assign unused_penable = ^bus.mgr_penable_i;

  // Scan from the manager after the last winner, wrapping, first requester wins.
  always_comb begin
    winner_next = last_grant_reg;
    req_any     = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NumMgr; k++) begin
      cand = IdxW'((int'(last_grant_reg) + k) % NumMgr);
      if (!req_any && bus.mgr_psel_i[cand]) begin
        winner_next = cand;
        req_any     = 1'b1;
      end
    end
  end

  always_comb begin
    addr_next  = '0;
    wdata_next = '0;
    write_next = 1'b0;
    for (int i = 0; i < NumMgr; i++) begin
      if (winner_next == IdxW'(i)) begin
        addr_next  = bus.mgr_paddr_i[i*AddrWidth +: AddrWidth];
        wdata_next = bus.mgr_pwdata_i[i*DataWidth +: DataWidth];
        write_next = bus.mgr_pwrite_i[i];
      end
    end
  end

  assign timeout_hit = (TimeoutCycles > 0) && (state_reg == ACCESS) && !bus.sub_pready_i
                       && (cnt_reg == CntW'(TimeoutCycles));
  assign resp_fire   = (state_reg == ACCESS) && (bus.sub_pready_i || timeout_hit);

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= IdxW'(NumMgr - 1);
      addr_reg       <= '0;
      wdata_reg      <= '0;
      write_reg      <= 1'b0;
      psel_reg       <= 1'b0;
      penable_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            grant_reg      <= winner_next;
            last_grant_reg <= winner_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            write_reg      <= write_next;
            cnt_reg        <= '0;
            psel_reg       <= 1'b1;
            penable_reg    <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= SETUP;
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (resp_fire) begin
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end else if (TimeoutCycles > 0) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          psel_reg    <= 1'b0;
          penable_reg <= 1'b0;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign bus.sub_psel_o    = psel_reg;
  assign bus.sub_penable_o = penable_reg;
  assign bus.sub_pwrite_o  = write_reg;
  assign bus.sub_paddr_o   = addr_reg;
  assign bus.sub_pwdata_o  = wdata_reg;
  assign busy_o            = busy_reg;
  assign timeout_o         = timeout_hit;

  // Only the granted manager ever sees a response; a watchdog kill returns zero data.
  for (genvar gi = 0; gi < NumMgr; gi++) begin : g_resp
    logic sel;
    assign sel = resp_fire && (grant_reg == IdxW'(gi));
    assign bus.mgr_pready_o[gi]  = sel;
    assign bus.mgr_pslverr_o[gi] = sel && (timeout_hit || bus.sub_pslverr_i);
    assign bus.mgr_prdata_o[gi*DataWidth +: DataWidth] =
        (sel && !timeout_hit) ? bus.sub_prdata_i : '0;
  end
endmodule

// File: tb/tb_apb_mgr_arbiter.sv
// Scoreboard bench for apb_mgr_arbiter: two managers and a scripted subordinate,
// expected completions queued when stimulus is issued and popped on each mgr_pready.
module tb_apb_mgr_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic timeout;

  apb_mgr_arbiter_if #(.NumMgr(NM), .AddrWidth(AW), .DataWidth(DW)) bus ();

  apb_mgr_arbiter #(.NumMgr(NM), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
    .clk_i     (clk),
    .rst_ni    (rst),
    .bus       (bus),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          mgr;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          waits;      // ACCESS wait states before pready; negative = never ready
    logic [31:0] sub_rdata;
    logic        sub_err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_cyc;    // completion cycle relative to the request's first cycle
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t m0_q[$];
  xfer_t m1_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  int    t0     = 0;
  bit    done0  = 1'b0;
  bit    done1  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic add(input int mgr, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                     input int waits, input logic [31:0] rd, input logic err, input int ecyc);
    xfer_t x;
    x.mgr       = mgr;
    x.addr      = addr;
    x.write     = wr;
    x.wdata     = wd;
    x.waits     = waits;
    x.sub_rdata = rd;
    x.sub_err   = err;
    x.exp_to    = (waits < 0);
    x.exp_rdata = (waits < 0) ? 32'h0 : rd;
    x.exp_err   = (waits < 0) ? 1'b1 : err;
    x.exp_cyc   = ecyc;
    exp_q.push_back(x);
    if (mgr == 0) m0_q.push_back(x);
    else          m1_q.push_back(x);
  endtask

  task automatic clear_all();
    exp_q.delete();
    m0_q.delete();
    m1_q.delete();
    done0 = 1'b0;
    done1 = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_sub_psel"},    bus.sub_psel_o,    0);
    check({pfx, "_sub_penable"}, bus.sub_penable_o, 0);
    check({pfx, "_sub_pwrite"},  bus.sub_pwrite_o,  0);
    check({pfx, "_sub_paddr"},   bus.sub_paddr_o,   0);
    check({pfx, "_sub_pwdata"},  bus.sub_pwdata_o,  0);
    check({pfx, "_mgr_pready"},  bus.mgr_pready_o,  0);
    check({pfx, "_mgr_pslverr"}, bus.mgr_pslverr_o, 0);
    check({pfx, "_mgr_prdata"},  bus.mgr_prdata_o,  0);
    check({pfx, "_busy"},        busy,              0);
    check({pfx, "_timeout"},     timeout,           0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    clear_all();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Next cycle after this call is cycle 0 of the test: requests become visible there.
  task automatic start();
    @(negedge clk); #2;
    t0 = cyc + 1;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() > 0; n++) @(negedge clk);
    if (exp_q.size() > 0) begin
      check("drain_pending", exp_q.size(), 0);
      clear_all();
    end
    repeat (2) @(negedge clk);
  endtask

  // Managers and subordinate model, driven just after each rising edge.
  initial begin
    logic [NM-1:0] psel_prev;
    int acc_cnt;
    acc_cnt = 0;
    bus.mgr_psel_i    = '0;
    bus.mgr_penable_i = '0;
    bus.mgr_pwrite_i  = '0;
    bus.mgr_paddr_i   = '0;
    bus.mgr_pwdata_i  = '0;
    bus.sub_prdata_i  = '0;
    bus.sub_pready_i  = 1'b0;
    bus.sub_pslverr_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (done0) begin m0_q.delete(0); done0 = 1'b0; end
      if (done1) begin m1_q.delete(0); done1 = 1'b0; end
      psel_prev = bus.mgr_psel_i;
      if (m0_q.size() > 0) begin
        bus.mgr_psel_i[0]        = 1'b1;
        bus.mgr_pwrite_i[0]      = m0_q[0].write;
        bus.mgr_paddr_i[0 +: AW] = m0_q[0].addr;
        bus.mgr_pwdata_i[0 +: DW] = m0_q[0].wdata;
      end else begin
        bus.mgr_psel_i[0] = 1'b0;
      end
      if (m1_q.size() > 0) begin
        bus.mgr_psel_i[1]          = 1'b1;
        bus.mgr_pwrite_i[1]        = m1_q[0].write;
        bus.mgr_paddr_i[AW +: AW]  = m1_q[0].addr;
        bus.mgr_pwdata_i[DW +: DW] = m1_q[0].wdata;
      end else begin
        bus.mgr_psel_i[1] = 1'b0;
      end
      bus.mgr_penable_i = psel_prev & bus.mgr_psel_i;
      if (bus.sub_psel_o && bus.sub_penable_o && exp_q.size() > 0) begin
        bus.sub_prdata_i  = exp_q[0].sub_rdata;
        bus.sub_pslverr_i = exp_q[0].sub_err;
        bus.sub_pready_i  = (exp_q[0].waits >= 0) && (acc_cnt == exp_q[0].waits);
        acc_cnt++;
      end else begin
        acc_cnt           = 0;
        bus.sub_prdata_i  = '0;
        bus.sub_pready_i  = 1'b0;
        bus.sub_pslverr_i = 1'b0;
      end
    end
  end

  // Monitor: subordinate-side address phase and manager-side completions.
  initial begin
    xfer_t x;
    logic [NM-1:0] oh;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.sub_psel_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_sub_xfer", bus.sub_psel_o, 0);
          end else begin
            check("sub_paddr",  bus.sub_paddr_o,  exp_q[0].addr);
            check("sub_pwrite", bus.sub_pwrite_o, exp_q[0].write);
            if (exp_q[0].write) check("sub_pwdata", bus.sub_pwdata_o, exp_q[0].wdata);
          end
        end
        if (timeout && bus.mgr_pready_o == '0) check("stray_timeout", timeout, 0);
        if (bus.mgr_pready_o != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pready", bus.mgr_pready_o, 0);
          end else begin
            x = exp_q.pop_front();
            oh = '0;
            oh[x.mgr] = 1'b1;
            check("pready_mgr", bus.mgr_pready_o, oh);
            check("prdata",     bus.mgr_prdata_o[x.mgr*DW +: DW], x.exp_rdata);
            check("pslverr",    bus.mgr_pslverr_o, x.exp_err ? oh : '0);
            check("timeout",    timeout, x.exp_to);
            check("done_cycle", cyc - t0, x.exp_cyc);
            $display("xfer mgr=%0d addr=%08h wr=%0d wdata=%08h rdata=%08h err=%0d to=%0d cyc=%0d",
                     x.mgr, x.addr, x.write, x.wdata, bus.mgr_prdata_o[x.mgr*DW +: DW],
                     bus.mgr_pslverr_o[x.mgr], timeout, cyc - t0);
            if (x.mgr == 0) done0 = 1'b1;
            else            done1 = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #2 check_all_zero("reset");
    rst = 1'b0;

    // Single zero-wait read, with busy/psel/penable per cycle.
    do_reset();
    start();
    add(0, 32'h0000_1004, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 2);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk); #2;
      check("single_busy",        busy,              (r == 1 || r == 2));
      check("single_sub_psel",    bus.sub_psel_o,    (r == 1 || r == 2));
      check("single_sub_penable", bus.sub_penable_o, (r == 2));
    end
    drain();

    // Simultaneous writes from both managers right after reset.
    do_reset();
    start();
    add(0, 32'h0000_2000, 1'b1, 32'h11, 0, 32'h0, 1'b0, 2);
    add(1, 32'h0000_2004, 1'b1, 32'h22, 0, 32'h0, 1'b0, 5);
    drain();

    // Fairness: both managers keep requesting for six transfers.
    do_reset();
    start();
    for (int k = 0; k < 6; k++)
      add(k % 2, 32'h0000_3000 + 32'(4 * k), (k % 3 == 0), 32'hA0 + 32'(k), 0,
          32'hC0DE_0000 + 32'(k), 1'b0, 2 + 3 * k);
    drain();

    // Four wait states followed by an error response.
    do_reset();
    start();
    add(0, 32'h0000_4008, 1'b0, 32'h0, 4, 32'h5A5A_5A5A, 1'b1, 6);
    drain();

    // Never-ready subordinate: watchdog kills manager 0, then manager 1 proceeds.
    do_reset();
    start();
    add(0, 32'h0000_5000, 1'b0, 32'h0, -1, 32'hBAD0_BAD0, 1'b0, TO + 2);
    add(1, 32'h0000_5004, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0, TO + 5);
    drain();

    // Reset during the second wait cycle of an ACCESS.
    do_reset();
    start();
    add(0, 32'h0000_6000, 1'b0, 32'h0, 4, 32'h0000_0001, 1'b0, 6);
    for (int r = 0; r < 4; r++) @(negedge clk);
    #2 check("midrst_in_access", bus.sub_penable_o, 1);
    rst = 1'b1;
    #1 check_all_zero("midrst");
    clear_all();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    start();
    add(0, 32'h0000_6100, 1'b0, 32'h0, 0, 32'h0000_6100, 1'b0, 2);
    add(1, 32'h0000_6104, 1'b1, 32'h77, 0, 32'h0, 1'b0, 5);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
